fpga_fabric: RTL and testbench



---
 rtl/fpga_fabric_pkg.sv | 64 ++++++
 rtl/fpga_fabric_cell.sv | 41 ++++
 rtl/fpga_fabric.sv | 93 +++++++++
 tb/tb_fpga_fabric.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_fabric_pkg.sv
// Shared constants, configuration-word field layout and decode helpers for
// the fpga_fabric logic fabric.
// No ports: imported by fpga_fabric and fpga_cell.
package fpga_fabric_pkg;

  localparam int N_SIDE        = 40;
  localparam int N_PADS        = 160;
  localparam int N_CELLS       = 64;
  localparam int SEL_W         = 8;
  localparam int CFG_W         = 224;
  localparam int CFG_WORDS     = 245;
  localparam int OUT_WORD_BASE = 64;

  // Source bus: pads, then cell outputs, then constant-zero filler.
  localparam int SRC_W         = 256;
  localparam int CELL_SRC_BASE = N_PADS;
  localparam int ZERO_SRC_W    = SRC_W - N_PADS - N_CELLS;

  // Field offsets inside a configuration word.
  localparam int SEL0    = 0;
  localparam int SEL1    = 8;
  localparam int SEL2    = 16;
  localparam int SEL3    = 24;
  localparam int LUT_LSB = 32;
  localparam int LUT_W   = 16;
  localparam int REG_BIT = 48;
  localparam int OE_BIT  = 8;

  // Only the meaningful bits of each word are kept; reserved bits are dropped.
  typedef struct packed {
    logic             registered;
    logic [LUT_W-1:0] lut;
    logic [SEL_W-1:0] sel3;
    logic [SEL_W-1:0] sel2;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel0;
  } cell_cfg_t;

  typedef struct packed {
    logic             enable;
    logic [SEL_W-1:0] sel;
  } pad_cfg_t;

  localparam int CELL_CFG_W = $bits(cell_cfg_t);

  function automatic cell_cfg_t decode_cell_cfg(input logic [CFG_W-1:0] word);
    cell_cfg_t c;
    c.sel0       = word[SEL0 +: SEL_W];
    c.sel1       = word[SEL1 +: SEL_W];
    c.sel2       = word[SEL2 +: SEL_W];
    c.sel3       = word[SEL3 +: SEL_W];
    c.lut        = word[LUT_LSB +: LUT_W];
    c.registered = word[REG_BIT];
    return c;
  endfunction

  function automatic pad_cfg_t decode_pad_cfg(input logic [CFG_W-1:0] word);
    pad_cfg_t p;
    p.sel    = word[SEL_W-1:0];
    p.enable = word[OE_BIT];
    return p;
  endfunction

endpackage

// File: rtl/fpga_fabric_cell.sv
// fpga_cell: one fabric logic cell. Four 256:1 input muxes from the source
// bus feed a LUT4; an enable flop with async clear captures the LUT output,
// and the cell output is either the flop or the raw LUT.
// Ports:
//   clock, rst   - clock and asynchronous active-high clear of the flop
//   ff_en        - flop clock enable
//   src[255:0]   - global source bus
//   cfg[48:0]    - packed cell_cfg_t (selects, truth table, registered bit)
//   cell_out     - cell output back onto the source bus
module fpga_cell
  import fpga_fabric_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  ff_en,
  input  logic [SRC_W-1:0]      src,
  input  logic [CELL_CFG_W-1:0] cfg,
  output logic                  cell_out
);

  cell_cfg_t  cfg_s;
  logic [3:0] lut_idx_s;
  logic       lut_out_s;
  logic       q_r;

  assign cfg_s     = cell_cfg_t'(cfg);
  assign lut_idx_s = {src[cfg_s.sel3], src[cfg_s.sel2], src[cfg_s.sel1], src[cfg_s.sel0]};
  assign lut_out_s = cfg_s.lut[lut_idx_s];

  // Cell flop: runs whether or not the output selects it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (ff_en) begin
      q_r <= lut_out_s;
    end
  end

  assign cell_out = cfg_s.registered ? q_r : lut_out_s;

endmodule

// File: rtl/fpga_fabric.sv
// fpga_fabric: bitstream-configurable logic fabric. Holds the configuration
// memory, builds the 256-entry source bus from pads and 64 cells, and drives
// 160 pad-output muxes.
// Ports:
//   clock, rst                  - clock; async active-high reset of config and flops
//   top/bot/left/right_in[39:0] - pad inputs (source bus 0..159)
//   top/bot/left/right_out[39:0]- pad outputs (config words 64..223)
//   ff_en                       - global cell flop enable
//   configs_en[244:0]           - one-hot-per-word write enables
//   configs_in[223:0]           - config write data
module fpga_fabric
  import fpga_fabric_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic [N_SIDE-1:0]    top_in,
  input  logic [N_SIDE-1:0]    bot_in,
  input  logic [N_SIDE-1:0]    left_in,
  input  logic [N_SIDE-1:0]    right_in,
  output logic [N_SIDE-1:0]    top_out,
  output logic [N_SIDE-1:0]    bot_out,
  output logic [N_SIDE-1:0]    left_out,
  output logic [N_SIDE-1:0]    right_out,
  input  logic                 ff_en,
  input  logic [CFG_WORDS-1:0] configs_en,
  input  logic [CFG_W-1:0]     configs_in
);

  cell_cfg_t          cell_cfg_r [N_CELLS];
  pad_cfg_t           pad_cfg_r  [N_PADS];
  logic [N_CELLS-1:0] cell_out_s;
  logic [SRC_W-1:0]   src_s;
  logic [N_PADS-1:0]  pad_out_s;
  logic               spare_unused_s;

  // Words 224..244 and reserved word bits have no function.
  assign spare_unused_s = ^{configs_en[CFG_WORDS-1:OUT_WORD_BASE+N_PADS],
                            configs_in[CFG_W-1:REG_BIT+1]};

  // Configuration memory: every enabled word takes the same write data.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CELLS; k++) begin
        cell_cfg_r[k] <= '0;
      end
      for (int j = 0; j < N_PADS; j++) begin
        pad_cfg_r[j] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CELLS; k++) begin
        if (configs_en[k]) begin
          cell_cfg_r[k] <= decode_cell_cfg(configs_in);
        end
      end
      for (int j = 0; j < N_PADS; j++) begin
        if (configs_en[OUT_WORD_BASE+j]) begin
          pad_cfg_r[j] <= decode_pad_cfg(configs_in);
        end
      end
    end
  end

  assign src_s = {{ZERO_SRC_W{1'b0}}, cell_out_s, right_in, left_in, bot_in, top_in};

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    fpga_cell u_cell (
      .clock    (clock),
      .rst      (rst),
      .ff_en    (ff_en),
      .src      (src_s),
      .cfg      (cell_cfg_r[i]),
      .cell_out (cell_out_s[i])
    );
  end

  // Pad-output muxes: a disabled pin is forced low.
  always_comb begin
    pad_out_s = '0;
    for (int j = 0; j < N_PADS; j++) begin
      if (pad_cfg_r[j].enable) begin
        pad_out_s[j] = src_s[pad_cfg_r[j].sel];
      end else begin
        pad_out_s[j] = 1'b0;
      end
    end
  end

  assign top_out   = pad_out_s[0*N_SIDE +: N_SIDE];
  assign bot_out   = pad_out_s[1*N_SIDE +: N_SIDE];
  assign left_out  = pad_out_s[2*N_SIDE +: N_SIDE];
  assign right_out = pad_out_s[3*N_SIDE +: N_SIDE];

endmodule

// File: tb/tb_fpga_fabric.sv
module tb_fpga_fabric;

  logic         clock;
  logic         rst;
  logic         ff_en;
  logic [39:0]  top_in, bot_in, left_in, right_in;
  logic [39:0]  top_out, bot_out, left_out, right_out;
  logic [244:0] configs_en;
  logic [223:0] configs_in;

  int checks = 0;
  int errors = 0;

  logic [159:0] exp_q [$];
  string        tag_q [$];
  event         sample_ev;

  localparam int PIN_R31 = 151;  // right_out[31]
  localparam int PIN_T6  = 6;    // top_out[6]

  fpga_fabric dut (
    .clock      (clock),
    .rst        (rst),
    .top_in     (top_in),
    .bot_in     (bot_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .top_out    (top_out),
    .bot_out    (bot_out),
    .left_out   (left_out),
    .right_out  (right_out),
    .ff_en      (ff_en),
    .configs_en (configs_en),
    .configs_in (configs_in)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cell word with reserved bits set to ones (they must be ignored).
  function automatic logic [223:0] cell_word(input logic [7:0] s0, input logic [7:0] s1,
                                             input logic [7:0] s2, input logic [7:0] s3,
                                             input logic [15:0] lut, input logic regd);
    logic [223:0] w;
    w = '1;
    w[7:0]   = s0;
    w[15:8]  = s1;
    w[23:16] = s2;
    w[31:24] = s3;
    w[47:32] = lut;
    w[48]    = regd;
    return w;
  endfunction

  function automatic logic [223:0] pad_word(input logic en, input logic [7:0] sel);
    logic [223:0] w;
    w = '1;
    w[7:0] = sel;
    w[8]   = en;
    return w;
  endfunction

  function automatic logic [159:0] pins(input int a, input int b);
    logic [159:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [159:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    -> sample_ev;
    #3;
  endtask

  task automatic write_word(input int k, input logic [223:0] d);
    configs_en    = '0;
    configs_en[k] = 1'b1;
    configs_in    = d;
    tick();
    configs_en    = '0;
  endtask

  // Monitor: samples the pad outputs on request and compares with the queue head.
  initial begin
    logic [159:0] got;
    logic [159:0] e;
    string        t;
    forever begin
      @(sample_ev);
      #2;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: sample requested with no expected entry");
      end else begin
        got = {right_out, left_out, bot_out, top_out};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got %h required %h", t, got, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ff_en = 1'b0;
    configs_en = '0; configs_in = '0;
    top_in = '0; bot_in = '0; left_in = '0; right_in = '0;

    // Reset state and pad-input independence.
    #12;
    expect_out("reset_state", '0);
    @(negedge clock); rst = 1'b0;
    tick();
    expect_out("after_release", '0);
    top_in = '1; bot_in = '1; left_in = '1; right_in = '1;
    expect_out("pads_all_high", '0);
    top_in = 40'h55_5555_5555; bot_in = 40'hAA_AAAA_AAAA;
    left_in = 40'h12_3456_789A; right_in = 40'hF0_F0F0_F0F0;
    expect_out("pads_pattern", '0);
    top_in = '0; bot_in = '0; left_in = '0; right_in = '0;
    expect_out("pads_all_low", '0);

    // Pass-through: right_out[31] <- right_in[26], no clock needed.
    write_word(215, pad_word(1'b1, 8'd146));
    right_in[26] = 1'b1;
    expect_out("pass_hi", pins(PIN_R31, -1));
    right_in[26] = 1'b0;
    expect_out("pass_lo", '0);

    // Registered NOR of right_in[26], right_in[29] on cell 0.
    ff_en = 1'b1;
    write_word(0, cell_word(8'd146, 8'd149, 8'd0, 8'd0, 16'h1111, 1'b1));
    write_word(215, pad_word(1'b1, 8'd160));
    expect_out("inv_init", pins(PIN_R31, -1));
    right_in[26] = 1'b1;
    expect_out("inv_before_edge", pins(PIN_R31, -1));
    tick();
    expect_out("inv_in0_hi", '0);
    right_in[26] = 1'b0;
    tick();
    expect_out("inv_in0_lo", pins(PIN_R31, -1));
    right_in[29] = 1'b1;
    tick();
    expect_out("inv_in1_hi", '0);

    // Flop hold with ff_en low: output stays 0 while the LUT toggles.
    ff_en = 1'b0;
    right_in[29] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      right_in[26] = ~right_in[26];
      tick();
      expect_out("hold", '0);
    end
    right_in[26] = 1'b0;
    ff_en = 1'b1;
    tick();
    expect_out("hold_release", pins(PIN_R31, -1));

    // Asynchronous reset between edges wipes config and flops.
    #2;
    rst = 1'b1;
    #1;
    expect_out("rst_async", '0);
    tick();
    tick();
    @(negedge clock); rst = 1'b0;
    tick();
    expect_out("rst_released_1", '0);
    tick();
    expect_out("rst_released_2", '0);
    write_word(0, cell_word(8'd146, 8'd149, 8'd0, 8'd0, 16'h1111, 1'b1));
    write_word(215, pad_word(1'b1, 8'd160));
    expect_out("rst_reload", pins(PIN_R31, -1));

    // Multi-word write: words 3 and 70 get identical data.
    write_word(215, pad_word(1'b1, 8'd163));
    right_in[26] = 1'b1;
    expect_out("cell3_unconfigured", '0);
    configs_en = '0;
    configs_en[3] = 1'b1;
    configs_en[70] = 1'b1;
    configs_in = '0;
    configs_in[7:0] = 8'd146;
    configs_in[8] = 1'b1;
    configs_in[47:32] = 16'hAAAA;
    tick();
    configs_en = '0;
    expect_out("multi_hi", pins(PIN_T6, PIN_R31));
    right_in[26] = 1'b0;
    expect_out("multi_lo", '0);

    // No enables: changing data must not write anything.
    right_in[26] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      configs_in = {7{32'(i * 32'h1357_9BDF)}};
      tick();
      expect_out("no_write", pins(PIN_T6, PIN_R31));
    end

    // Words 224..244 have no effect, singly or all at once.
    for (int k = 224; k < 245; k++) begin
      write_word(k, '1);
    end
    expect_out("high_words_single", pins(PIN_T6, PIN_R31));
    configs_en = '0;
    configs_en[244:224] = '1;
    configs_in = '0;
    tick();
    configs_en = '0;
    expect_out("high_words_multi", pins(PIN_T6, PIN_R31));

    // Final reset clears everything again.
    rst = 1'b1;
    #1;
    expect_out("final_reset", '0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
